// File: rtl/avalon_mem_if_mux_pkg.sv
// Shared types for the N-to-1 Avalon-MM memory multiplexer.
package avalon_mem_mux_pkg;

  localparam int TAG_CH_W = 4;   // up to 16 channels
  localparam int TAG_BC_W = 16;  // widest burstcount a tag can hold

  typedef struct packed {
    logic [TAG_CH_W-1:0] channel;
    logic [TAG_BC_W-1:0] burstcount;
  } t_rd_tag;

  typedef enum logic [0:0] {
    ARB      = 1'b0,
    WR_BURST = 1'b1
  } t_mux_state;

  function automatic int f_ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/avalon_mem_if_mux_if.sv
// Avalon-MM bundle; NUM_CHANNELS>1 packs per-channel fields side by side, readdata is shared.
interface avalon_mem_if_mux_if #(
  parameter int NUM_CHANNELS    = 1,
  parameter int DATA_WIDTH      = 512,
  parameter int ADDR_WIDTH      = 27,
  parameter int BURST_CNT_WIDTH = 7
) ();
  logic [NUM_CHANNELS*ADDR_WIDTH-1:0]      address;
  logic [NUM_CHANNELS*BURST_CNT_WIDTH-1:0] burstcount;
  logic [NUM_CHANNELS-1:0]                 read;
  logic [NUM_CHANNELS-1:0]                 write;
  logic [NUM_CHANNELS*DATA_WIDTH-1:0]      writedata;
  logic [NUM_CHANNELS*DATA_WIDTH/8-1:0]    byteenable;
  logic [NUM_CHANNELS-1:0]                 waitrequest;
  logic [DATA_WIDTH-1:0]                   readdata;
  logic [NUM_CHANNELS-1:0]                 readdatavalid;

  modport master (
    output address, burstcount, read, write, writedata, byteenable,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, burstcount, read, write, writedata, byteenable,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/avalon_mem_if_mux_tag_fifo.sv
// In-order tag FIFO: registered count drives full/empty, head is read combinationally.
// Caller never pushes when full nor pops when empty.
module avalon_mem_mux_tag_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_dat,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head_dat,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_push_dat;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (i_push && !i_pop)      r_count <= r_count + 1'b1;
      else if (!i_push && i_pop) r_count <= r_count - 1'b1;
    end
  end

  assign o_head_dat = r_mem[r_rd_ptr];
  assign o_full     = (r_count == (AW+1)'(DEPTH));
  assign o_empty    = (r_count == '0);
endmodule

// File: rtl/avalon_mem_if_mux.sv
// N-to-1 Avalon-MM mux: burst-aware round-robin command path, read data steered by in-order tags.
// Zero-latency command path; reads stall while the tag FIFO is full.
module avalon_mem_if_mux
  import avalon_mem_mux_pkg::*;
#(
  parameter int NUM_CHANNELS       = 2,
  parameter int DATA_WIDTH         = 512,
  parameter int ADDR_WIDTH         = 27,
  parameter int BURST_CNT_WIDTH    = 7,
  parameter int MAX_READS_INFLIGHT = 64
) (
  input  logic                clk,
  input  logic                reset_n,
  avalon_mem_if_mux_if.slave  s,
  avalon_mem_if_mux_if.master m,
  output logic                err_unexpected_rsp
);
  localparam int CH_IDX_W = f_ch_idx_w(NUM_CHANNELS);
  localparam int BW       = BURST_CNT_WIDTH;
  localparam int BEW      = DATA_WIDTH / 8;

  t_mux_state          r_state, w_state_nxt;
  logic [CH_IDX_W-1:0] r_rr_next, w_rr_next_nxt;  // first index searched on the next arbitration
  logic [CH_IDX_W-1:0] r_burst_ch, w_burst_ch_nxt;
  logic [BW-1:0]       r_wr_left, w_wr_left_nxt;
  logic [BW-1:0]       r_rsp_cnt;
  logic                r_err;

  logic [CH_IDX_W-1:0]     w_grant, w_grant_inc;
  logic [NUM_CHANNELS-1:0] w_req;
  logic [BW-1:0]           w_bc_raw, w_bc_eff, w_rsp_beat;
  logic                    w_m_read, w_m_write, w_accept;
  logic                    w_tag_full, w_tag_empty, w_tag_push, w_tag_pop, w_rsp_vld;
  t_rd_tag                 w_tag_in, w_tag_head;

  assign w_req = s.read | s.write;

  always_comb begin
    int idx;
    idx     = 0;
    w_grant = '0;
    if (r_state == WR_BURST) begin
      w_grant = r_burst_ch;
    end else begin
      // Walk from the far end so the nearest requester wins.
      for (int k = NUM_CHANNELS - 1; k >= 0; k--) begin
        idx = (int'(r_rr_next) + k) % NUM_CHANNELS;
        if (w_req[idx]) w_grant = CH_IDX_W'(idx);
      end
    end
  end

  assign w_grant_inc = (int'(w_grant) == NUM_CHANNELS - 1) ? '0 : w_grant + 1'b1;
  assign w_bc_raw    = s.burstcount[int'(w_grant)*BW +: BW];
  assign w_bc_eff    = (w_bc_raw == '0) ? BW'(1) : w_bc_raw;

  always_comb begin
    w_m_read  = 1'b0;
    w_m_write = 1'b0;
    if (reset_n) begin
      if (r_state == ARB) begin
        w_m_read  = s.read[w_grant] && !w_tag_full;
        w_m_write = s.write[w_grant] && !s.read[w_grant];
      end else begin
        w_m_write = s.write[w_grant];
      end
    end
  end

  assign w_accept     = (w_m_read || w_m_write) && !m.waitrequest[0];
  assign m.read       = w_m_read;
  assign m.write      = w_m_write;
  assign m.address    = s.address[int'(w_grant)*ADDR_WIDTH +: ADDR_WIDTH];
  assign m.burstcount = w_bc_eff;
  assign m.writedata  = s.writedata[int'(w_grant)*DATA_WIDTH +: DATA_WIDTH];
  assign m.byteenable = s.byteenable[int'(w_grant)*BEW +: BEW];

  always_comb begin
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      s.waitrequest[i] = !(w_accept && (int'(w_grant) == i));
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_rr_next_nxt  = r_rr_next;
    w_burst_ch_nxt = r_burst_ch;
    w_wr_left_nxt  = r_wr_left;
    if (w_accept) begin
      case (r_state)
        ARB: begin
          if (w_m_write && (w_bc_eff > BW'(1))) begin
            w_state_nxt    = WR_BURST;
            w_burst_ch_nxt = w_grant;
            w_wr_left_nxt  = w_bc_eff - BW'(1);
          end else begin
            w_rr_next_nxt = w_grant_inc;
          end
        end
        WR_BURST: begin
          w_wr_left_nxt = r_wr_left - BW'(1);
          if (r_wr_left == BW'(1)) begin
            w_state_nxt   = ARB;
            w_rr_next_nxt = w_grant_inc;
          end
        end
        default: w_state_nxt = ARB;
      endcase
    end
  end

  assign w_tag_push          = w_m_read && !m.waitrequest[0];
  assign w_tag_in.channel    = TAG_CH_W'(w_grant);
  assign w_tag_in.burstcount = TAG_BC_W'(w_bc_eff);

  avalon_mem_mux_tag_fifo #(
    .WIDTH ($bits(t_rd_tag)),
    .DEPTH (MAX_READS_INFLIGHT)
  ) u_tag_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_push     (w_tag_push),
    .i_push_dat (w_tag_in),
    .i_pop      (w_tag_pop),
    .o_head_dat (w_tag_head),
    .o_full     (w_tag_full),
    .o_empty    (w_tag_empty)
  );

  assign w_rsp_vld  = m.readdatavalid[0] && !w_tag_empty;
  assign w_rsp_beat = r_rsp_cnt + BW'(1);
  assign w_tag_pop  = w_rsp_vld && (TAG_BC_W'(w_rsp_beat) == w_tag_head.burstcount);
  assign s.readdata = m.readdata;

  always_comb begin
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      s.readdatavalid[i] = w_rsp_vld && (w_tag_head.channel == TAG_CH_W'(i));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ARB;
      r_rr_next  <= '0;
      r_burst_ch <= '0;
      r_wr_left  <= '0;
      r_rsp_cnt  <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_rr_next  <= w_rr_next_nxt;
      r_burst_ch <= w_burst_ch_nxt;
      r_wr_left  <= w_wr_left_nxt;
      if (w_rsp_vld) r_rsp_cnt <= w_tag_pop ? '0 : w_rsp_beat;
      if (m.readdatavalid[0] && w_tag_empty) r_err <= 1'b1;
    end
  end

  assign err_unexpected_rsp = r_err;

  a_bc_nonzero: assert property (@(posedge clk) disable iff (!reset_n)
    (r_state == ARB && w_accept) |-> (w_bc_raw != '0));
endmodule

// File: tb/tb_avalon_mem_if_mux.sv
// Directed vector bench for avalon_mem_if_mux (2 channels, 4-deep tag FIFO).
module tb_avalon_mem_if_mux;
  localparam int N  = 2;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int BW = 4;
  localparam logic [DW-1:0] WD0 = 32'hA5A5_0000;
  localparam logic [DW-1:0] WD1 = 32'h5A5A_1111;

  typedef struct {
    logic [1:0]    rd;
    logic [1:0]    wr;
    logic [BW-1:0] bc0;
    logic [BW-1:0] bc1;
    logic          mw;
    logic          rdv;
    logic [AW-1:0] e_addr;
    logic          e_mrd;
    logic          e_mwr;
    logic [1:0]    e_sw;
    logic [1:0]    e_rdv;
    logic          e_err;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic err_unexpected_rsp;
  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t vq[$];

  always #5 clk = ~clk;

  avalon_mem_if_mux_if #(.NUM_CHANNELS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_CNT_WIDTH(BW)) s_if ();
  avalon_mem_if_mux_if #(.NUM_CHANNELS(1), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_CNT_WIDTH(BW)) m_if ();

  avalon_mem_if_mux #(
    .NUM_CHANNELS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .BURST_CNT_WIDTH(BW), .MAX_READS_INFLIGHT(4)
  ) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .s                  (s_if),
    .m                  (m_if),
    .err_unexpected_rsp (err_unexpected_rsp)
  );

  task automatic add(input logic [1:0] rd, input logic [1:0] wr, input logic [BW-1:0] bc0,
                     input logic [BW-1:0] bc1, input logic mw, input logic rdv,
                     input logic [AW-1:0] ea, input logic emrd, input logic emwr,
                     input logic [1:0] esw, input logic [1:0] erdv, input logic eerr);
    vec_t v;
    v.rd = rd; v.wr = wr; v.bc0 = bc0; v.bc1 = bc1; v.mw = mw; v.rdv = rdv;
    v.e_addr = ea; v.e_mrd = emrd; v.e_mwr = emwr; v.e_sw = esw; v.e_rdv = erdv; v.e_err = eerr;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic logic [BW-1:0] eff(input logic [BW-1:0] b);
    return (b == '0) ? BW'(1) : b;
  endfunction

  function automatic logic [127:0] ctl_snap();
    return 128'({m_if.read, m_if.write, s_if.waitrequest, s_if.readdatavalid, err_unexpected_rsp});
  endfunction

  function automatic logic [127:0] ctl_exp(input logic mrd, input logic mwr, input logic [1:0] sw,
                                          input logic [1:0] rdv, input logic err);
    return 128'({mrd, mwr, sw, rdv, err});
  endfunction

  task automatic drive(input logic [1:0] rd, input logic [1:0] wr, input logic [BW-1:0] bc0,
                       input logic [BW-1:0] bc1, input logic mw, input logic rdv);
    s_if.read = rd;
    s_if.write = wr;
    s_if.burstcount = {bc1, bc0};
    m_if.waitrequest = mw;
    m_if.readdatavalid = rdv;
  endtask

  initial begin
    logic [127:0] got, exp;
    logic [BW-1:0] ebc;
    logic [DW-1:0] ewd;

    s_if.address    = {8'h20, 8'h10};
    s_if.writedata  = {WD1, WD0};
    s_if.byteenable = '1;
    m_if.readdata   = '0;
    drive(2'b11, 2'b00, 4'd1, 4'd1, 1'b0, 1'b1);

    // Round-robin reads, one response beat per cycle.
    add(2'b11,2'b00,1,1,0,0, 8'h10,1,0,2'b10,2'b00,0);
    add(2'b11,2'b00,1,1,0,1, 8'h20,1,0,2'b01,2'b01,0);
    add(2'b11,2'b00,1,1,0,1, 8'h10,1,0,2'b10,2'b10,0);
    add(2'b11,2'b00,1,1,0,1, 8'h20,1,0,2'b01,2'b01,0);
    add(2'b00,2'b00,1,1,0,1, 8'h10,0,0,2'b11,2'b10,0);
    // ch0 write burst of 4 (one stalled cycle) blocks ch1 read until it ends.
    add(2'b10,2'b01,4,1,0,0, 8'h10,0,1,2'b10,2'b00,0);
    add(2'b10,2'b01,4,1,1,0, 8'h10,0,1,2'b11,2'b00,0);
    add(2'b10,2'b01,4,1,0,0, 8'h10,0,1,2'b10,2'b00,0);
    add(2'b10,2'b01,4,1,0,0, 8'h10,0,1,2'b10,2'b00,0);
    add(2'b10,2'b01,4,1,0,0, 8'h10,0,1,2'b10,2'b00,0);
    add(2'b10,2'b00,4,1,0,0, 8'h20,1,0,2'b01,2'b00,0);
    add(2'b00,2'b00,4,1,0,1, 8'h10,0,0,2'b11,2'b10,0);
    // ch1 read x8 then ch0 read x2; ten beats split 8/2.
    add(2'b10,2'b00,2,8,0,0, 8'h20,1,0,2'b01,2'b00,0);
    add(2'b01,2'b00,2,8,0,0, 8'h10,1,0,2'b10,2'b00,0);
    for (int b = 1; b <= 10; b++)
      add(2'b00,2'b00,2,8,0,1, 8'h10,0,0,2'b11,(b <= 8) ? 2'b10 : 2'b01,0);
    // Fill the 4-deep tag FIFO; 5th read waits for the first burst's last beat to pop.
    add(2'b01,2'b00,2,1,0,0, 8'h10,1,0,2'b10,2'b00,0);
    for (int k = 0; k < 3; k++)
      add(2'b01,2'b00,1,1,0,0, 8'h10,1,0,2'b10,2'b00,0);
    add(2'b01,2'b00,1,1,0,0, 8'h10,0,0,2'b11,2'b00,0);
    add(2'b01,2'b00,1,1,0,1, 8'h10,0,0,2'b11,2'b01,0);
    add(2'b01,2'b00,1,1,0,1, 8'h10,0,0,2'b11,2'b01,0);
    add(2'b01,2'b00,1,1,0,0, 8'h10,1,0,2'b10,2'b00,0);
    for (int k = 0; k < 4; k++)
      add(2'b00,2'b00,1,1,0,1, 8'h10,0,0,2'b11,2'b01,0);
    // Stray response beats: dropped, sticky error.
    add(2'b00,2'b00,1,1,0,1, 8'h10,0,0,2'b11,2'b00,0);
    add(2'b00,2'b00,1,1,0,0, 8'h10,0,0,2'b11,2'b00,1);
    add(2'b00,2'b00,1,1,0,1, 8'h10,0,0,2'b11,2'b00,1);

    #2;
    check("reset_state", ctl_snap(), ctl_exp(0, 0, 2'b11, 2'b00, 0));
    @(negedge clk);
    drive(2'b00, 2'b00, 4'd1, 4'd1, 1'b0, 1'b0);
    reset_n = 1'b1;

    foreach (vq[i]) begin
      @(negedge clk);
      drive(vq[i].rd, vq[i].wr, vq[i].bc0, vq[i].bc1, vq[i].mw, vq[i].rdv);
      m_if.readdata = 32'hD000_0000 + DW'(i);
      #1;
      ebc = eff((vq[i].e_addr == 8'h10) ? vq[i].bc0 : vq[i].bc1);
      ewd = (vq[i].e_addr == 8'h10) ? WD0 : WD1;
      got = {m_if.read, m_if.write, s_if.waitrequest, s_if.readdatavalid, err_unexpected_rsp,
             s_if.readdata, 44'h0, 32'h0};
      exp = {vq[i].e_mrd, vq[i].e_mwr, vq[i].e_sw, vq[i].e_rdv, vq[i].e_err,
             m_if.readdata, 44'h0, 32'h0};
      if (vq[i].e_mrd || vq[i].e_mwr) begin
        got[75:0] = {m_if.address, m_if.burstcount, m_if.writedata, 32'h0};
        exp[75:0] = {vq[i].e_addr, ebc, ewd, 32'h0};
      end
      check($sformatf("vec%0d", i), got, exp);
    end

    // Reset in the middle of a ch0 write burst.
    @(negedge clk);
    drive(2'b00, 2'b01, 4'd4, 4'd1, 1'b0, 1'b0);
    #1 check("burst_beat1", ctl_snap(), ctl_exp(0, 1, 2'b10, 2'b00, 1));
    @(negedge clk);
    #1 check("burst_beat2", ctl_snap(), ctl_exp(0, 1, 2'b10, 2'b00, 1));
    reset_n = 1'b0;
    m_if.readdatavalid = 1'b1;
    #1 check("reset_mid_burst", ctl_snap(), ctl_exp(0, 0, 2'b11, 2'b00, 0));
    @(negedge clk);
    reset_n = 1'b1;
    drive(2'b10, 2'b01, 4'd4, 4'd1, 1'b0, 1'b0);
    #1 check("post_reset_ch0_first", ctl_snap(), ctl_exp(0, 1, 2'b10, 2'b00, 0));
    check("post_reset_addr", 128'(m_if.address), 128'(8'h10));
    @(negedge clk);
    drive(2'b00, 2'b00, 4'd4, 4'd1, 1'b0, 1'b1);
    #1 check("stray_after_reset", ctl_snap(), ctl_exp(0, 0, 2'b11, 2'b00, 0));
    @(negedge clk);
    m_if.readdatavalid = 1'b0;
    #1 check("stray_sets_err", ctl_snap(), ctl_exp(0, 0, 2'b11, 2'b00, 1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
